// File: rtl/uart_rx_deser.sv
// UART receive deserialiser (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a
// small first-word-fall-through FIFO with pop/valid handshake and one-cycle error pulses.
`timescale 1ns/1ps

module uart_rx_deser #(
  parameter int CLK_HZ     = 10_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rx_rd_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic          sync1, sync2, rxd_prev;
  logic          start_edge, restart, tick, decide, bit_val;
  logic [DW-1:0] div_cnt;
  state_t        state;
  logic [3:0]    s;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [1:0]    smp;
  logic          push_req, ferr_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      sync1    <= rxd;
      sync2    <= sync1;
      rxd_prev <= sync2;
    end
  end

  assign start_edge = rxd_prev & ~sync2;
  assign restart    = (state == IDLE) && start_edge;
  assign tick       = (div_cnt == DW'(DIV - 1));
  // Decision happens on the tick that moves s onto 9; samples were taken as s stepped onto 7 and 8.
  assign decide     = tick && (s == 4'd8);
  assign bit_val    = maj3(smp[0], smp[1], sync2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      div_cnt <= '0;
    else if (restart || tick)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + DW'(1);
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad, perr_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      s        <= 4'd0;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      smp      <= 2'b11;
      push_req <= 1'b0;
      ferr_req <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad  <= 1'b0;
      perr_req <= 1'b0;
`endif
    end else begin
      push_req <= 1'b0;
      ferr_req <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_req <= 1'b0;
`endif
      if (tick) s <= s + 4'd1;
      if (tick && s == 4'd6) smp[0] <= sync2;
      if (tick && s == 4'd7) smp[1] <= sync2;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state <= START;
            s     <= 4'd0;
          end
        end
        START: begin
          if (decide) begin
            state   <= bit_val ? IDLE : DATA;
            bit_cnt <= 3'd0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
          end
        end
        DATA: begin
          if (decide) begin
            shift   <= {bit_val, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (decide) begin
            par_bad <= (bit_val != ^shift);
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          // Return to IDLE at mid-stop so a following start edge is not missed.
          if (decide) begin
            state <= IDLE;
            if (!bit_val)
              ferr_req <= 1'b1;
`ifdef UART_RX_PARITY_EN
            else if (par_bad)
              perr_req <= 1'b1;
`endif
            else
              push_req <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, head_addr;
  logic [CW-1:0] count, count_next;
  logic          pop, push, full_now, ovr_now;

  assign full_now   = (count == CW'(FIFO_DEPTH));
  assign pop        = rx_rd_en && (count != '0);
  assign push       = push_req && (!full_now || pop);
  assign ovr_now    = push_req && full_now && !pop;
  assign head_addr  = pop ? rd_ptr + AW'(1) : rd_ptr;
  assign count_next = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      rx_data   <= 8'h00;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      count     <= count_next;
      frame_err <= ferr_req;
      overrun   <= ovr_now;
      // Head register bypasses the array when the new head is the byte being written.
      if (count_next == '0)
        rx_data <= 8'h00;
      else if (push && wr_ptr == head_addr)
        rx_data <= shift;
      else
        rx_data <= mem[head_addr];
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      parity_err <= 1'b0;
    else
      parity_err <= perr_req;
  end
`else
  assign parity_err = 1'b0;
`endif

  assign rx_valid = (count != '0);
  assign rx_empty = ~rx_valid;
  assign rx_full  = full_now;

endmodule
